// File: rtl/proc_input_feeder.sv
// Producer side of the processor enter/in1 handshake: a small byte FIFO drained one byte per INPUT visit.
// Optional idle-starvation counter on stall_cycles is enabled by defining FEEDER_STALL_CNT_EN.
module proc_input_feeder #(
    parameter int          DEPTH       = 8,
    parameter logic [3:0]  STATE_INPUT = 4'b1100,
    parameter int          CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic [3:0]       proc_state,
    input  logic             proc_halt,
    output logic             enter,
    output logic [7:0]       in1,
    output logic [7:0]       consumed,
    output logic [15:0]      stall_cycles
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full, r_empty, r_overflow, r_enter;
    logic [7:0]       r_in1, r_consumed;

    logic             w_wr, w_pop, w_present, w_release;
    logic [CNT_W-1:0] w_count_next;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign w_wr         = wr_en && !r_full;
    assign w_count_next = r_count + CNT_W'(w_wr) - CNT_W'(w_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_present    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (proc_halt) begin
                    w_state_next = S_HALTED;
                end else if (proc_state == STATE_INPUT && !r_empty) begin
                    w_state_next = S_PRESENT;
                    w_present    = 1'b1;
                end
            end
            S_PRESENT: begin
                if (proc_halt) begin
                    w_state_next = S_HALTED;
                    w_release    = 1'b1;
                end else if (proc_state != STATE_INPUT) begin
                    w_state_next = S_IDLE;
                    w_release    = 1'b1;
                    w_pop        = 1'b1;
                end
            end
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_enter    <= 1'b0;
            r_in1      <= '0;
            r_consumed <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
            if (wr_en && r_full)
                r_overflow <= 1'b1;
            if (w_present) begin
                r_enter <= 1'b1;
                r_in1   <= r_mem[r_rd_ptr];
            end else if (w_release) begin
                r_enter <= 1'b0;
            end
            if (w_pop)
                r_consumed <= r_consumed + 8'd1;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= wr_data;
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_stall <= '0;
        else if (r_state == S_IDLE && proc_state == STATE_INPUT && r_empty && !proc_halt
                 && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign enter    = r_enter;
    assign in1      = r_in1;
    assign consumed = r_consumed;

endmodule

// File: doc/proc_input_feeder.md
Name: proc_input_feeder

Overview:
- Producer side of the processor's `enter`/`in1` input handshake.
- Buffers bytes written by a host or bench in a small FIFO.
- When the processor sits in its INPUT state, presents the head byte on `in1` with `enter` asserted, and pops it once the processor leaves INPUT.
- Stops feeding permanently once the processor halts.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
STATE_INPUT, 4'b1100, processor state code for the INPUT (wait-for-enter) state
CNT_W, 4, width of count output; must hold 0..DEPTH

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
wr_en  in  1  host write strobe, one byte per cycle
wr_data  in  8  host byte
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  CNT_W  current occupancy
overflow  out  1  sticky: write attempted while full
proc_state  in  4  processor state code (showstate)
proc_halt  in  1  processor halt flag
enter  out  1  to processor: input byte valid
in1  out  8  to processor: input byte
consumed  out  8  bytes delivered since reset, wraps 255->0
stall_cycles  out  16  see Optional Feature

Behaviour:
- Reset (async, any time, including mid-handshake): FIFO emptied, pointers 0, `enter`=0, `in1`=0, `overflow`=0, `consumed`=0, `stall_cycles`=0, FSM=IDLE. `empty`=1, `full`=0, `count`=0.
- All outputs are registered; the FSM samples `proc_state` and `proc_halt` at rising edges.
- FIFO write: accepted when `wr_en`=1 and `full`=0.
  - Write while `full`=1 is dropped and sets `overflow`.
  - The drop applies even if a pop occurs in the same cycle.
- Write to an empty FIFO: the byte is visible as head on the next cycle. `in1` never shows the byte in the cycle of its write.
- Simultaneous write and pop (not full): `count` is unchanged; both take effect.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - `proc_halt`=1 -> HALTED.
    - `proc_state`==STATE_INPUT and `empty`=0 -> PRESENT. Registered `enter`<=1 and `in1`<=head, so `enter` rises 1 cycle after INPUT is first sampled.
    - INPUT and empty -> stay in IDLE (starved); `enter` stays 0.
  - PRESENT:
    - `enter`=1, `in1` held stable.
    - When `proc_state`!=STATE_INPUT is sampled: pop the head, `enter`<=0, `consumed`++, -> IDLE.
    - `proc_halt`=1 -> `enter`<=0, no pop, -> HALTED.
  - HALTED: `enter`=0, no pops; FIFO writes still accepted. Left only by reset.
- `in1` holds its last presented value after `enter` falls (not cleared).
- Back-to-back inputs: the processor re-enters INPUT at the earliest 1 cycle after leaving. IDLE re-arms on that sample; the next byte is presented without a gap cycle beyond the required one.
- No pop without a completed handshake: leaving INPUT while in IDLE has no effect.

Optional Feature:
- Macro: FEEDER_STALL_CNT_EN.
- Defined: `stall_cycles` increments, saturating at 16'hFFFF, on every cycle FSM=IDLE with `proc_state`==STATE_INPUT, `empty`=1 and `proc_halt`=0. Cleared only by reset.
- Undefined: counter logic absent; `stall_cycles` tied to 0.

Test Plan:
- Reset then write 8'd9; hold `proc_state`=1100 -> `enter`=1, `in1`=9 one cycle after INPUT is sampled. Move state to 0000 -> next cycle `enter`=0, `empty`=1, `consumed`=1.
- Write 3,5,7; pulse INPUT three times separated by 0001/0010 states -> `in1` shows 3, 5, 7 in order; `consumed`=3; `count` goes 3->0.
- Hold INPUT with FIFO empty for 10 cycles, then write 8'h42 -> `enter` stays 0 during the stall, then asserts with `in1`=42. With FEEDER_STALL_CNT_EN, `stall_cycles`=10; without it, 0.
- Write 9 bytes with DEPTH=8 -> `full`=1 after the 8th write, 9th dropped, `overflow`=1, `count`=8. The drop also holds when a pop coincides with a write while full.
- In PRESENT, assert `proc_halt` -> `enter`=0 next cycle, `count` unchanged, further INPUT states ignored until reset.
- Assert `reset` asynchronously mid-PRESENT -> `enter`, `in1`, `count`, `consumed`, `overflow` all 0 immediately, without waiting for a clock edge.
